// File: rtl/fifo.sv
// Synchronous FIFO with registered read data, per-port ack/err pulses and
// current/next occupancy outputs.
// Optional feature macro: FIFO_ERR_FLAGS_EN. When it is defined, wr_err and
// rd_err pulse for rejected requests. When it is undefined (the default),
// both ports are tied low.
// reset_n is an active-high synchronous reset despite its name; the name is
// kept because the surrounding codebase uses it.
module fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [ADDR_WIDTH:0]   next_data_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_DEPTH  = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic                  wr_ack_q, rd_ack_q;

  logic wr_ok;
  logic rd_ok;

  // Status flags come straight from the registered occupancy.
  assign full  = (count_q == CNT_DEPTH);
  assign empty = (count_q == CNT_ZERO);

  // Each request is judged against the pre-edge state, independently of the other.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      d_out_d  = mem_q[rd_ptr_q];
    end

    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage array; left uninitialised by reset because only pointers and count matter.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset_n) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

  // Pointers, occupancy, read data and acknowledge pulses.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      d_out_q  <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      d_out_q  <= d_out_d;
      wr_ack_q <= wr_ok;
      rd_ack_q <= rd_ok;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic wr_err_q, rd_err_q;

  // Error pulses for requests that arrived while full or empty.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && full;
      rd_err_q <= rd_en && empty;
    end
  end

  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign d_out           = d_out_q;
  assign wr_ack          = wr_ack_q;
  assign rd_ack          = rd_ack_q;
  assign data_count      = count_q;
  assign next_data_count = count_d;

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed scenarios, then a randomized run.
// Every cycle is checked against a queue-based reference model.
module tb_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  logic [AW:0]   data_count;
  logic [AW:0]   next_data_count;

  always #5 clk = ~clk;

  fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .rd_en           (rd_en),
    .d_in            (d_in),
    .d_out           (d_out),
    .full            (full),
    .empty           (empty),
    .wr_ack          (wr_ack),
    .wr_err          (wr_err),
    .rd_ack          (rd_ack),
    .rd_err          (rd_err),
    .data_count      (data_count),
    .next_data_count (next_data_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stored words in order, plus the expected registered outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_wack, m_werr, m_rack, m_rerr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one clock cycle against the model and checks the DUT before and after the edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] din, input logic rst);
    int sz;
    bit mfull, mempty, wa, ra;
    int exp_next;
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    d_in    = din;
    reset_n = rst;
    sz      = mq.size();
    mfull   = (sz == DEPTH);
    mempty  = (sz == 0);
    wa      = w && !mfull;
    ra      = r && !mempty;
    #1;
    if (!rst) begin
      exp_next = sz + ((wa && !ra) ? 1 : 0) - ((ra && !wa) ? 1 : 0);
      check("next_count", 64'(next_data_count), 64'(exp_next));
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
    end else begin
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(din);
      m_wack = wa;
      m_rack = ra;
      m_werr = ERR_EN && w && mfull;
      m_rerr = ERR_EN && r && mempty;
    end
    #1;
    check("count",  64'(data_count), 64'(mq.size()));
    check("full",   64'(full),   64'(mq.size() == DEPTH));
    check("empty",  64'(empty),  64'(mq.size() == 0));
    check("d_out",  64'(d_out),  64'(m_dout));
    check("wr_ack", 64'(wr_ack), 64'(m_wack));
    check("wr_err", 64'(wr_err), 64'(m_werr));
    check("rd_ack", 64'(rd_ack), 64'(m_rack));
    check("rd_err", 64'(rd_err), 64'(m_rerr));
    check("ack_err_excl", 64'((wr_ack && wr_err) || (rd_ack && rd_err)), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] exp_rd [9];
    int pw, pr;
    exp_rd = '{32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'hcc, 32'h0};
    reset_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;
    m_dout = '0; m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;

    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("rst_count", 64'(data_count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));

    // Read from empty after reset.
    step(1'b0, 1'b1, '0, 1'b0);
    check("empty_rd_err", 64'(rd_err), 64'(ERR_EN));
    check("empty_rd_ack", 64'(rd_ack), 64'(0));
    check("empty_d_out",  64'(d_out),  64'(0));

    // Fill to the top, then one write too many.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, DW'(32'h11 * i), 1'b0);
      check("fill_count", 64'(data_count), 64'(i));
    end
    check("fill_full", 64'(full), 64'(1));
    step(1'b1, 1'b0, 32'h99, 1'b0);
    check("over_wr_err", 64'(wr_err), 64'(ERR_EN));
    check("over_count",  64'(data_count), 64'(8));

    // Read one, refill, then drain across the pointer wrap.
    step(1'b0, 1'b1, '0, 1'b0);
    check("first_rd", 64'(d_out), 64'(32'h11));
    check("first_cnt", 64'(data_count), 64'(7));
    step(1'b1, 1'b0, 32'hcc, 1'b0);
    check("refill_cnt", 64'(data_count), 64'(8));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check("drain_data", 64'(d_out), 64'(exp_rd[i]));
    end
    step(1'b0, 1'b1, '0, 1'b0);
    check("drain_rd_err", 64'(rd_err), 64'(ERR_EN));
    check("drain_hold", 64'(d_out), 64'(32'hcc));

    // Simultaneous read and write at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(32'ha0 + i), 1'b0);
    step(1'b1, 1'b1, 32'hb0, 1'b0);
    check("both_cnt", 64'(data_count), 64'(3));
    check("both_acks", 64'({wr_ack, rd_ack}), 64'(2'b11));

    // Reset with a write pending at count 5.
    step(1'b1, 1'b0, 32'hb1, 1'b0);
    step(1'b1, 1'b0, 32'hb2, 1'b0);
    check("pre_rst_cnt", 64'(data_count), 64'(5));
    step(1'b1, 1'b0, 32'hb3, 1'b1);
    check("mid_rst_cnt", 64'(data_count), 64'(0));
    check("mid_rst_flags", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'(0));
    step(1'b0, 1'b1, '0, 1'b0);
    check("post_rst_rd_err", 64'(rd_err), 64'(ERR_EN));

    // Randomized traffic with shifting read/write bias and rare resets.
    pw = 50; pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        pw = int'($urandom_range(90, 10));
        pr = int'($urandom_range(90, 10));
      end
      step(($urandom_range(99) < 32'(pw)), ($urandom_range(99) < 32'(pr)),
           DW'($urandom()), ($urandom_range(299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
